regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 28 ++
 rtl/regfile_wb_arbiter_if.sv | 51 +++++
 rtl/regfile_wb_arbiter_register_file.sv | 30 +++
 rtl/regfile_wb_arbiter_rf_scoreboard.sv | 50 +++++
 rtl/regfile_wb_arbiter.sv | 96 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter, its scoreboard and the
// register file it feeds.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Identifies which writeback source won (or last won) the write port.
  typedef enum logic {
    REQ_ALU  = 1'b0,
    REQ_LOAD = 1'b1
  } req_idx_t;

  // One-hot mask of a register index. Register 0 is hard-wired to zero, so it
  // never produces a mask bit.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t addr,
                                                     input logic      en);
    logic [NUM_REGS-1:0] mask;
    mask = '0;
    if (en && (addr != '0)) begin
      mask[addr] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the writeback request ports, the register-file write port, the
// issue-time reservation port and the hazard-lookup port of the arbiter.
interface regfile_wb_arbiter_if #(parameter int N = 32);
  import regfile_pkg::*;

  logic                wb0_valid;
  logic                wb0_ready;
  reg_addr_t           wb0_addr;
  logic [N-1:0]        wb0_data;

  logic                wb1_valid;
  logic                wb1_ready;
  reg_addr_t           wb1_addr;
  logic [N-1:0]        wb1_data;

  logic                wr_ena;
  reg_addr_t           wr_addr;
  logic [N-1:0]        wr_data;

  logic                rsv_ena;
  reg_addr_t           rsv_addr;

  reg_addr_t           rd_addr0;
  reg_addr_t           rd_addr1;
  logic                rd_busy0;
  logic                rd_busy1;
  logic [NUM_REGS-1:0] pending;

  // Pipeline side: issues reservations, raises writebacks, asks about hazards.
  modport master (
    output wb0_valid, wb0_addr, wb0_data,
    output wb1_valid, wb1_addr, wb1_data,
    output rsv_ena, rsv_addr,
    output rd_addr0, rd_addr1,
    input  wb0_ready, wb1_ready,
    input  wr_ena, wr_addr, wr_data,
    input  rd_busy0, rd_busy1, pending
  );

  // Arbiter side.
  modport slave (
    input  wb0_valid, wb0_addr, wb0_data,
    input  wb1_valid, wb1_addr, wb1_data,
    input  rsv_ena, rsv_addr,
    input  rd_addr0, rd_addr1,
    output wb0_ready, wb1_ready,
    output wr_ena, wr_addr, wr_data,
    output rd_busy0, rd_busy1, pending
  );

endinterface

// File: rtl/regfile_wb_arbiter_register_file.sv
// 32-entry register file with one write port and one combinational read port;
// register 0 always reads as zero and ignores writes.
module register_file
  import regfile_pkg::*;
#(
  parameter int N = 32
) (
  input  logic      clk,
  input  logic      wr_ena,
  input  reg_addr_t wr_addr,
  input  logic [N-1:0] wr_data,
  input  reg_addr_t raddr,
  output logic [N-1:0] rdata
);

  logic [N-1:0] regs [NUM_REGS];

  // Write port; register 0 is never stored.
  always_ff @(posedge clk) begin
    if (wr_ena && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read port, with register 0 forced to zero.
  always_comb begin
    rdata = (raddr == '0) ? '0 : regs[raddr];
  end

endmodule

// File: rtl/regfile_wb_arbiter_rf_scoreboard.sv
// Tracks which destination registers have an outstanding writeback and answers
// source-operand hazard queries, including the one cycle where the value is
// still sitting in the write-port register and not yet in the register file.
module rf_scoreboard
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_ena,
  input  reg_addr_t           set_addr,
  input  logic                clr_ena,
  input  reg_addr_t           clr_addr,
  input  logic                wr_ena,
  input  reg_addr_t           wr_addr,
  input  reg_addr_t           rd_addr0,
  input  reg_addr_t           rd_addr1,
  output logic [NUM_REGS-1:0] pending,
  output logic                rd_busy0,
  output logic                rd_busy1
);

  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  // Decode reservation and retirement into masks; index 0 never yields a bit.
  always_comb begin
    set_mask = reg_onehot(set_addr, set_ena);
    clr_mask = reg_onehot(clr_addr, clr_ena);
  end

  // Clear first, then set, so a same-cycle reserve of a retiring register
  // leaves it marked busy for the newly issued producer.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  // A source is busy while reserved, or while its value is only in flight on
  // the registered write port.
  always_comb begin
    rd_busy0 = pending[rd_addr0] |
               (wr_ena && (wr_addr == rd_addr0) && (rd_addr0 != '0));
    rd_busy1 = pending[rd_addr1] |
               (wr_ena && (wr_addr == rd_addr1) && (rd_addr1 != '0));
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter in front of a single register-file write port.
// ALU and load unit compete round-robin; the winner is registered onto the
// write port one cycle later and its scoreboard reservation is retired.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);

  req_idx_t     last_grant;
  logic         grant0;
  logic         grant1;
  logic         xfer;
  logic         wr_go;
  req_idx_t     win_idx;
  reg_addr_t    win_addr;
  logic [N-1:0] win_data;

  logic         wr_ena_q;
  reg_addr_t    wr_addr_q;
  logic [N-1:0] wr_data_q;

  // Grant: a lone requester wins; a conflict goes to whoever did not win the
  // previous transfer. Nothing is granted while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (bus.wb0_valid && bus.wb1_valid) begin
        grant0 = (last_grant == REQ_LOAD);
        grant1 = (last_grant == REQ_ALU);
      end else begin
        grant0 = bus.wb0_valid;
        grant1 = bus.wb1_valid;
      end
    end
  end

  // Select the winning request; a transfer to register 0 is accepted but
  // never becomes a register-file write.
  always_comb begin
    xfer     = grant0 | grant1;
    win_idx  = grant1 ? REQ_LOAD : REQ_ALU;
    win_addr = grant1 ? bus.wb1_addr : bus.wb0_addr;
    win_data = grant1 ? bus.wb1_data : bus.wb0_data;
    wr_go    = xfer && (win_addr != '0);
  end

  assign bus.wb0_ready = grant0;
  assign bus.wb1_ready = grant1;

  // Write-port registers and round-robin pointer; address and data hold
  // their last written values when no write is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ena_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      last_grant <= REQ_LOAD;
    end else begin
      wr_ena_q <= wr_go;
      if (wr_go) begin
        wr_addr_q <= win_addr;
        wr_data_q <= win_data;
      end
      if (xfer) begin
        last_grant <= win_idx;
      end
    end
  end

  assign bus.wr_ena  = wr_ena_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

  rf_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_ena  (bus.rsv_ena),
    .set_addr (bus.rsv_addr),
    .clr_ena  (xfer),
    .clr_addr (win_addr),
    .wr_ena   (wr_ena_q),
    .wr_addr  (wr_addr_q),
    .rd_addr0 (bus.rd_addr0),
    .rd_addr1 (bus.rd_addr1),
    .pending  (bus.pending),
    .rd_busy0 (bus.rd_busy0),
    .rd_busy1 (bus.rd_busy1)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand sequences for the
// scoreboard and reset corners, then a randomized run against a small model.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;

  int n_checks;
  int n_fail;

  regfile_wb_arbiter_if #(.N(32)) bus ();

  regfile_wb_arbiter #(.N(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  register_file #(.N(32)) u_rf (
    .clk     (clk),
    .wr_ena  (bus.wr_ena),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .raddr   (rf_raddr),
    .rdata   (rf_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        exp_r0;
    logic        exp_r1;
    logic        exp_ena;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [12];

  // Reference model state for the randomized phase.
  logic        m_last;
  logic [31:0] m_pend;
  logic        m_ena;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_regs [32];
  logic [31:0] m_written;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic setIdle();
    bus.wb0_valid = 1'b0;
    bus.wb0_addr  = 5'd0;
    bus.wb0_data  = 32'd0;
    bus.wb1_valid = 1'b0;
    bus.wb1_addr  = 5'd0;
    bus.wb1_data  = 32'd0;
    bus.rsv_ena   = 1'b0;
    bus.rsv_addr  = 5'd0;
    bus.rd_addr0  = 5'd0;
    bus.rd_addr1  = 5'd0;
  endtask

  task automatic applyStimulus(input vec_t v);
    setIdle();
    bus.wb0_valid = v.v0;
    bus.wb0_addr  = v.a0;
    bus.wb0_data  = v.d0;
    bus.wb1_valid = v.v1;
    bus.wb1_addr  = v.a1;
    bus.wb1_data  = v.d1;
  endtask

  task automatic checkReg(input logic [4:0] a, input logic [31:0] exp_val,
                          input string name);
    rf_raddr = a;
    #1;
    checkOutput(name, {32'd0, rf_rdata}, {32'd0, exp_val});
  endtask

  // One model-checked cycle. mode 0: random inputs, 1: idle, 2: idle with reset.
  task automatic randomCycle(input int mode, input int iter);
    logic        g0, g1, eb0, eb1, wgo;
    logic [4:0]  wa;
    logic [31:0] wd;
    @(negedge clk);
    setIdle();
    rst = (mode == 2);
    if (mode == 0) begin
      rst           = ($urandom_range(0, 63) == 0);
      bus.wb0_valid = 1'($urandom_range(0, 1));
      bus.wb0_addr  = 5'($urandom_range(0, 31));
      bus.wb0_data  = $urandom;
      bus.wb1_valid = 1'($urandom_range(0, 1));
      bus.wb1_addr  = 5'($urandom_range(0, 31));
      bus.wb1_data  = $urandom;
      bus.rsv_ena   = 1'($urandom_range(0, 1));
      bus.rsv_addr  = 5'($urandom_range(0, 31));
      bus.rd_addr0  = 5'($urandom_range(0, 31));
      bus.rd_addr1  = 5'($urandom_range(0, 31));
    end
    #1;
    g0  = !rst && bus.wb0_valid && (!bus.wb1_valid || m_last);
    g1  = !rst && bus.wb1_valid && (!bus.wb0_valid || !m_last);
    eb0 = m_pend[bus.rd_addr0] || (m_ena && m_addr == bus.rd_addr0 && bus.rd_addr0 != 5'd0);
    eb1 = m_pend[bus.rd_addr1] || (m_ena && m_addr == bus.rd_addr1 && bus.rd_addr1 != 5'd0);
    checkOutput($sformatf("rnd%0d wb0_ready", iter), {63'd0, bus.wb0_ready}, {63'd0, g0});
    checkOutput($sformatf("rnd%0d wb1_ready", iter), {63'd0, bus.wb1_ready}, {63'd0, g1});
    checkOutput($sformatf("rnd%0d rd_busy0", iter), {63'd0, bus.rd_busy0}, {63'd0, eb0});
    checkOutput($sformatf("rnd%0d rd_busy1", iter), {63'd0, bus.rd_busy1}, {63'd0, eb1});
    @(posedge clk);
    if (m_ena && m_addr != 5'd0) begin
      m_regs[m_addr]    = m_data;
      m_written[m_addr] = 1'b1;
    end
    if (rst) begin
      m_last = 1'b1;
      m_pend = 32'd0;
      m_ena  = 1'b0;
      m_addr = 5'd0;
      m_data = 32'd0;
    end else begin
      wgo = 1'b0;
      wa  = g1 ? bus.wb1_addr : bus.wb0_addr;
      wd  = g1 ? bus.wb1_data : bus.wb0_data;
      if (g0 || g1) begin
        m_last = g1;
        if (wa != 5'd0) begin
          m_pend[wa] = 1'b0;
          wgo        = 1'b1;
        end
      end
      if (bus.rsv_ena && bus.rsv_addr != 5'd0) m_pend[bus.rsv_addr] = 1'b1;
      m_ena = wgo;
      if (wgo) begin
        m_addr = wa;
        m_data = wd;
      end
    end
    #1;
    checkOutput($sformatf("rnd%0d wr_ena", iter), {63'd0, bus.wr_ena}, {63'd0, m_ena});
    checkOutput($sformatf("rnd%0d wr_addr", iter), {59'd0, bus.wr_addr}, {59'd0, m_addr});
    checkOutput($sformatf("rnd%0d wr_data", iter), {32'd0, bus.wr_data}, {32'd0, m_data});
    checkOutput($sformatf("rnd%0d pending", iter), {32'd0, bus.pending}, {32'd0, m_pend});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rf_raddr = 5'd0;
    setIdle();
    rst = 1'b1;

    vecs[0]  = '{1'b1, 5'd3,  32'hA,        1'b1, 5'd5,  32'hB,        1'b1, 1'b0, 1'b1, 5'd3,  32'hA};
    vecs[1]  = '{1'b1, 5'd3,  32'hA,        1'b1, 5'd5,  32'hB,        1'b0, 1'b1, 1'b1, 5'd5,  32'hB};
    vecs[2]  = '{1'b1, 5'd3,  32'hA,        1'b1, 5'd5,  32'hB,        1'b1, 1'b0, 1'b1, 5'd3,  32'hA};
    vecs[3]  = '{1'b1, 5'd3,  32'hA,        1'b1, 5'd5,  32'hB,        1'b0, 1'b1, 1'b1, 5'd5,  32'hB};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd5,  32'hB};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 5'd7,  32'hDEADBEEF};
    vecs[6]  = '{1'b1, 5'd0,  32'h1234,     1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 5'd7,  32'hDEADBEEF};
    vecs[7]  = '{1'b1, 5'd10, 32'h10,       1'b1, 5'd11, 32'h11,       1'b0, 1'b1, 1'b1, 5'd11, 32'h11};
    vecs[8]  = '{1'b1, 5'd1,  32'h55,       1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd1,  32'h55};
    vecs[9]  = '{1'b1, 5'd2,  32'h22,       1'b1, 5'd12, 32'hCC,       1'b0, 1'b1, 1'b1, 5'd12, 32'hCC};
    vecs[10] = '{1'b1, 5'd20, 32'h2020,     1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd20, 32'h2020};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd21, 32'h2121,     1'b0, 1'b1, 1'b1, 5'd21, 32'h2121};

    $display("[TB] reset");
    @(negedge clk);
    bus.wb0_valid = 1'b1;
    bus.wb1_valid = 1'b1;
    #1;
    checkOutput("reset wb0_ready", {63'd0, bus.wb0_ready}, 64'd0);
    checkOutput("reset wb1_ready", {63'd0, bus.wb1_ready}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    setIdle();
    rst = 1'b0;
    #1;
    checkOutput("reset wr_ena",  {63'd0, bus.wr_ena},  64'd0);
    checkOutput("reset wr_addr", {59'd0, bus.wr_addr}, 64'd0);
    checkOutput("reset wr_data", {32'd0, bus.wr_data}, 64'd0);
    checkOutput("reset pending", {32'd0, bus.pending}, 64'd0);

    $display("[TB] vector table");
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d wb0_ready", i), {63'd0, bus.wb0_ready}, {63'd0, vecs[i].exp_r0});
      checkOutput($sformatf("vec%0d wb1_ready", i), {63'd0, bus.wb1_ready}, {63'd0, vecs[i].exp_r1});
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d wr_ena", i),  {63'd0, bus.wr_ena},  {63'd0, vecs[i].exp_ena});
      checkOutput($sformatf("vec%0d wr_addr", i), {59'd0, bus.wr_addr}, {59'd0, vecs[i].exp_addr});
      checkOutput($sformatf("vec%0d wr_data", i), {32'd0, bus.wr_data}, {32'd0, vecs[i].exp_data});
    end
    @(negedge clk);
    setIdle();
    @(posedge clk);
    @(negedge clk);
    checkReg(5'd0,  32'h0,        "rf r0");
    checkReg(5'd1,  32'h55,       "rf r1");
    checkReg(5'd3,  32'hA,        "rf r3");
    checkReg(5'd5,  32'hB,        "rf r5");
    checkReg(5'd7,  32'hDEADBEEF, "rf r7");
    checkReg(5'd11, 32'h11,       "rf r11");
    checkReg(5'd12, 32'hCC,       "rf r12");
    checkReg(5'd20, 32'h2020,     "rf r20");
    checkReg(5'd21, 32'h2121,     "rf r21");

    $display("[TB] reserve x9, retire four cycles later");
    @(negedge clk);
    setIdle();
    bus.rsv_ena  = 1'b1;
    bus.rsv_addr = 5'd9;
    bus.rd_addr0 = 5'd9;
    #1;
    checkOutput("rsv9 busy0 before", {63'd0, bus.rd_busy0}, 64'd0);
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.rsv_ena  = (c == 0);
      bus.rsv_addr = 5'd0;
      #1;
      checkOutput($sformatf("rsv9 busy0 c%0d", c), {63'd0, bus.rd_busy0}, 64'd1);
      checkOutput($sformatf("rsv9 busy1 c%0d", c), {63'd0, bus.rd_busy1}, 64'd0);
      checkOutput($sformatf("rsv9 pending c%0d", c), {32'd0, bus.pending}, 64'h200);
      @(posedge clk);
    end
    @(negedge clk);
    bus.rsv_ena   = 1'b0;
    bus.wb0_valid = 1'b1;
    bus.wb0_addr  = 5'd9;
    bus.wb0_data  = 32'h99;
    #1;
    checkOutput("rsv9 wb0_ready", {63'd0, bus.wb0_ready}, 64'd1);
    checkOutput("rsv9 busy0 xfer", {63'd0, bus.rd_busy0}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.wb0_valid = 1'b0;
    #1;
    checkOutput("rsv9 wr_ena",     {63'd0, bus.wr_ena},     64'd1);
    checkOutput("rsv9 wr_addr",    {59'd0, bus.wr_addr},    64'd9);
    checkOutput("rsv9 pending9",   {63'd0, bus.pending[9]}, 64'd0);
    checkOutput("rsv9 busy0 wr",   {63'd0, bus.rd_busy0},   64'd1);
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rsv9 busy0 after", {63'd0, bus.rd_busy0}, 64'd0);
    checkOutput("rsv9 wr_ena after", {63'd0, bus.wr_ena}, 64'd0);

    $display("[TB] same-cycle reserve and retire of x4");
    @(negedge clk);
    setIdle();
    bus.rsv_ena   = 1'b1;
    bus.rsv_addr  = 5'd4;
    bus.wb1_valid = 1'b1;
    bus.wb1_addr  = 5'd4;
    bus.wb1_data  = 32'h44;
    #1;
    checkOutput("x4 wb1_ready", {63'd0, bus.wb1_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    setIdle();
    #1;
    checkOutput("x4 pending4", {63'd0, bus.pending[4]}, 64'd1);
    checkOutput("x4 wr_ena",   {63'd0, bus.wr_ena},     64'd1);
    checkOutput("x4 wr_addr",  {59'd0, bus.wr_addr},    64'd4);
    bus.wb0_valid = 1'b1;
    bus.wb0_addr  = 5'd4;
    bus.wb0_data  = 32'h40;
    #1;
    checkOutput("x4 wb0_ready", {63'd0, bus.wb0_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    setIdle();
    #1;
    checkOutput("x4 pending4 clear", {63'd0, bus.pending[4]}, 64'd0);
    checkOutput("x4 wr_data",        {32'd0, bus.wr_data},    64'h40);

    $display("[TB] reset pulse after a transfer");
    @(negedge clk);
    bus.wb0_valid = 1'b1;
    bus.wb0_addr  = 5'd6;
    bus.wb0_data  = 32'h66;
    bus.rsv_ena   = 1'b1;
    bus.rsv_addr  = 5'd8;
    #1;
    checkOutput("rstp wb0_ready pre", {63'd0, bus.wb0_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst           = 1'b1;
    bus.wb0_valid = 1'b1;
    bus.wb0_addr  = 5'd20;
    bus.wb0_data  = 32'hBAD0;
    bus.wb1_valid = 1'b1;
    bus.wb1_addr  = 5'd21;
    bus.wb1_data  = 32'hBAD1;
    bus.rsv_addr  = 5'd13;
    #1;
    checkOutput("rstp wb0_ready in rst", {63'd0, bus.wb0_ready}, 64'd0);
    checkOutput("rstp wb1_ready in rst", {63'd0, bus.wb1_ready}, 64'd0);
    checkOutput("rstp wr_ena in flight", {63'd0, bus.wr_ena},    64'd1);
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rstp wr_ena",  {63'd0, bus.wr_ena},  64'd0);
    checkOutput("rstp wr_addr", {59'd0, bus.wr_addr}, 64'd0);
    checkOutput("rstp wr_data", {32'd0, bus.wr_data}, 64'd0);
    checkOutput("rstp pending", {32'd0, bus.pending}, 64'd0);
    rst          = 1'b0;
    bus.rsv_ena  = 1'b0;
    bus.wb0_addr = 5'd14;
    bus.wb0_data = 32'h1414;
    bus.wb1_addr = 5'd15;
    bus.wb1_data = 32'h1515;
    #1;
    checkOutput("rstp conflict wb0_ready", {63'd0, bus.wb0_ready}, 64'd1);
    checkOutput("rstp conflict wb1_ready", {63'd0, bus.wb1_ready}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    setIdle();
    #1;
    checkOutput("rstp wr_addr 14", {59'd0, bus.wr_addr}, 64'd14);
    checkOutput("rstp wr_data 14", {32'd0, bus.wr_data}, 64'h1414);
    @(posedge clk);
    @(negedge clk);
    checkReg(5'd14, 32'h1414, "rf r14");
    checkReg(5'd20, 32'h2020, "rf r20 after rst");
    checkReg(5'd21, 32'h2121, "rf r21 after rst");

    $display("[TB] randomized run");
    m_last    = 1'b1;
    m_pend    = 32'd0;
    m_ena     = 1'b0;
    m_addr    = 5'd0;
    m_data    = 32'd0;
    m_written = 32'd0;
    for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
    randomCycle(2, -1);
    for (int i = 0; i < 1000; i++) begin
      randomCycle(0, i);
    end
    randomCycle(1, 1000);
    randomCycle(1, 1001);
    @(negedge clk);
    for (int r = 1; r < 32; r++) begin
      if (m_written[r]) begin
        checkReg(5'(r), m_regs[r], $sformatf("rnd rf r%0d", r));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
